// File: rtl/avalon_pio_multi_out.sv
// Multi-channel Avalon-MM output PIO with double-buffered channels.
// Software writes shadow registers. All active registers then load together,
// either immediately or at the next rising edge of sync_in, so downstream
// logic never sees a half-updated configuration.
module avalon_pio_multi_out #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 16,
  parameter logic [NUM_CH*WIDTH-1:0] RESET_VALUES = {NUM_CH{WIDTH'(15)}}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic                    read_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  input  logic                    sync_in,
  output logic [NUM_CH*WIDTH-1:0] out_port,
  output logic                    update_pulse,
  output logic                    commit_pending
);

  localparam int unsigned TOTAL_W     = NUM_CH * WIDTH;
  localparam logic [3:0]  ACTIVE_BASE = 4'h8;
  localparam logic [3:0]  CTRL_ADDR   = 4'hF;

  logic [TOTAL_W-1:0] shadow_q, shadow_d;
  logic [TOTAL_W-1:0] active_q, active_d;
  logic               auto_q;
  logic               sync_en_q;
  logic               pending_q, pending_d;
  logic               sync_d_q;

  logic               wr_en;
  logic               rd_en;
  logic               ctrl_wr;
  logic               commit_now;
  logic               arm;
  logic               cancel;
  logic               sync_edge;
  logic               sync_fire;
  logic               commit_load;
  logic               auto_wr;
  logic [WIDTH-1:0]   wdata_w;
  logic [31:0]        rdata_c;
  logic               unused_wdata;

  // Only the low WIDTH bits and the CTRL bits carry meaning.
  assign unused_wdata = ^writedata;

  // Bus strobe decode and commit qualification.
  always_comb begin
    wr_en       = chipselect & ~write_n;
    rd_en       = chipselect & ~read_n;
    ctrl_wr     = wr_en && (address == CTRL_ADDR);
    commit_now  = ctrl_wr & writedata[0] & ~writedata[2];
    arm         = ctrl_wr & writedata[0] & writedata[2];
    cancel      = ctrl_wr & ~writedata[0] & ~writedata[2];
    sync_edge   = sync_in & ~sync_d_q;
    // An arm in the same cycle as an edge keeps waiting for the next edge.
    sync_fire   = pending_q & sync_edge & ~arm;
    commit_load = commit_now | sync_fire;
    wdata_w     = writedata[WIDTH-1:0];
  end

  // Next shadow/active values; a commit takes pre-write shadow contents.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    auto_wr  = 1'b0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (wr_en && (address == 4'(c))) begin
        shadow_d[c*WIDTH +: WIDTH] = wdata_w;
        auto_wr = auto_q;
      end
    end
    if (commit_load) begin
      active_d = shadow_q;
    end else if (auto_wr) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (address == 4'(c)) begin
          active_d[c*WIDTH +: WIDTH] = wdata_w;
        end
      end
    end
  end

  // Deferred-commit arm/fire/cancel tracking.
  always_comb begin
    pending_d = pending_q;
    if (commit_now) begin
      pending_d = 1'b0;
    end else if (arm) begin
      pending_d = 1'b1;
    end else if (sync_fire || cancel) begin
      pending_d = 1'b0;
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rdata_c = 32'd0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (address == 4'(c)) begin
        rdata_c = 32'(shadow_q[c*WIDTH +: WIDTH]);
      end
      if (address == (ACTIVE_BASE + 4'(c))) begin
        rdata_c = 32'(active_q[c*WIDTH +: WIDTH]);
      end
    end
    if (address == CTRL_ADDR) begin
      rdata_c = {23'd0, pending_q, 5'd0, sync_en_q, auto_q, 1'b0};
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q     <= RESET_VALUES;
      active_q     <= RESET_VALUES;
      auto_q       <= 1'b0;
      sync_en_q    <= 1'b0;
      pending_q    <= 1'b0;
      sync_d_q     <= 1'b0;
      update_pulse <= 1'b0;
      readdata     <= 32'd0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      sync_d_q     <= sync_in;
      update_pulse <= commit_load | auto_wr;
      if (ctrl_wr) begin
        auto_q    <= writedata[1];
        sync_en_q <= writedata[2];
      end
      if (rd_en) begin
        readdata <= rdata_c;
      end
    end
  end

  assign out_port       = active_q;
  assign commit_pending = pending_q;

endmodule

// File: tb/tb_avalon_pio_multi_out.sv
// Directed testbench for avalon_pio_multi_out (NUM_CH=4, WIDTH=16).
module tb_avalon_pio_multi_out;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned TOT_W  = NUM_CH * WIDTH;

  logic             clk;
  logic             reset;
  logic [3:0]       address;
  logic             chipselect;
  logic             write_n;
  logic             read_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             sync_in;
  logic [TOT_W-1:0] out_port;
  logic             update_pulse;
  logic             commit_pending;

  int n_checks;
  int n_pass;

  avalon_pio_multi_out #(
    .NUM_CH(NUM_CH),
    .WIDTH (WIDTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .read_n        (read_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .sync_in       (sync_in),
    .out_port      (out_port),
    .update_pulse  (update_pulse),
    .commit_pending(commit_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle write; returns at the negedge after the capturing posedge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  task automatic sync_pulse();
    @(negedge clk);
    sync_in = 1'b1;
    @(negedge clk);
    sync_in = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    bus_write(4'hF, 32'h2);
    bus_write(4'h1, 32'h0000_BEEF);
    bus_write(4'hF, 32'h5);
    n_checks++;
    if (commit_pending !== 1'b1) $display("FAIL pre_reset_pending got=%0b exp=1", commit_pending);
    else n_pass++;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if (out_port !== 64'h000F_000F_000F_000F) $display("FAIL reset_out_port got=%h exp=000f000f000f000f", out_port);
    else n_pass++;
    n_checks++;
    if (commit_pending !== 1'b0 || update_pulse !== 1'b0 || readdata !== 32'd0)
      $display("FAIL reset_flags got=%0b/%0b/%h exp=0/0/0", commit_pending, update_pulse, readdata);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    bus_read(4'h8, rd);
    n_checks++;
    if (rd !== 32'h0000_000F) $display("FAIL reset_read_active0 got=%h exp=0000000f", rd);
    else n_pass++;
    bus_read(4'hF, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL reset_read_ctrl got=%h exp=00000000", rd);
    else n_pass++;
    bus_read(4'h1, rd);
    n_checks++;
    if (rd !== 32'h0000_000F) $display("FAIL reset_read_shadow1 got=%h exp=0000000f", rd);
    else n_pass++;
  endtask

  task automatic test_buffered_write();
    logic [31:0] rd;
    bus_write(4'h2, 32'h0000_1234);
    n_checks++;
    if (out_port !== 64'h000F_000F_000F_000F || update_pulse !== 1'b0)
      $display("FAIL buf_no_update got=%h/%0b exp=000f000f000f000f/0", out_port, update_pulse);
    else n_pass++;
    bus_read(4'h2, rd);
    n_checks++;
    if (rd !== 32'h0000_1234) $display("FAIL buf_read_shadow2 got=%h exp=00001234", rd);
    else n_pass++;
    bus_read(4'hA, rd);
    n_checks++;
    if (rd !== 32'h0000_000F) $display("FAIL buf_read_active2 got=%h exp=0000000f", rd);
    else n_pass++;
    bus_write(4'hF, 32'h1);
    n_checks++;
    if (out_port !== 64'h000F_1234_000F_000F || update_pulse !== 1'b1)
      $display("FAIL buf_commit got=%h/%0b exp=000f1234000f000f/1", out_port, update_pulse);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (update_pulse !== 1'b0) $display("FAIL buf_pulse_width got=%0b exp=0", update_pulse);
    else n_pass++;
  endtask

  task automatic test_deferred_commit();
    logic hold_ok;
    logic any_pulse;
    bus_write(4'h0, 32'h0000_0400);
    bus_write(4'hF, 32'h5);
    n_checks++;
    if (commit_pending !== 1'b1 || update_pulse !== 1'b0)
      $display("FAIL def_armed got=%0b/%0b exp=1/0", commit_pending, update_pulse);
    else n_pass++;
    hold_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_port !== 64'h000F_1234_000F_000F || update_pulse !== 1'b0 || commit_pending !== 1'b1)
        hold_ok = 1'b0;
    end
    n_checks++;
    if (hold_ok !== 1'b1) $display("FAIL def_hold_50 got=%h exp=000f1234000f000f", out_port);
    else n_pass++;
    // sync_in rises and stays high for three cycles
    @(negedge clk);
    sync_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_port !== 64'h000F_1234_000F_0400 || update_pulse !== 1'b1 || commit_pending !== 1'b0)
      $display("FAIL def_fire got=%h/%0b/%0b exp=000f1234000f0400/1/0", out_port, update_pulse, commit_pending);
    else n_pass++;
    any_pulse = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (update_pulse !== 1'b0) any_pulse = 1'b1;
    end
    sync_in = 1'b0;
    sync_pulse();
    repeat (3) begin
      @(negedge clk);
      if (update_pulse !== 1'b0) any_pulse = 1'b1;
    end
    n_checks++;
    if (any_pulse !== 1'b0 || out_port !== 64'h000F_1234_000F_0400)
      $display("FAIL def_no_retrigger got=%0b/%h exp=0/000f1234000f0400", any_pulse, out_port);
    else n_pass++;
  endtask

  task automatic test_cancel();
    logic [31:0] rd;
    bus_write(4'h0, 32'h0000_0777);
    bus_write(4'hF, 32'h5);
    n_checks++;
    if (commit_pending !== 1'b1) $display("FAIL cancel_armed got=%0b exp=1", commit_pending);
    else n_pass++;
    bus_write(4'hF, 32'h0);
    n_checks++;
    if (commit_pending !== 1'b0 || out_port !== 64'h000F_1234_000F_0400)
      $display("FAIL cancel_clear got=%0b/%h exp=0/000f1234000f0400", commit_pending, out_port);
    else n_pass++;
    sync_pulse();
    @(negedge clk);
    n_checks++;
    if (update_pulse !== 1'b0 || out_port !== 64'h000F_1234_000F_0400)
      $display("FAIL cancel_sync_ignored got=%0b/%h exp=0/000f1234000f0400", update_pulse, out_port);
    else n_pass++;
    bus_read(4'hF, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL cancel_read_ctrl got=%h exp=00000000", rd);
    else n_pass++;
  endtask

  task automatic test_collision();
    logic [31:0] rd;
    bus_write(4'h1, 32'h0000_0010);
    bus_write(4'hF, 32'h5);
    // shadow write lands in the same cycle as the sync edge
    @(negedge clk);
    sync_in = 1'b1;
    address = 4'h1; writedata = 32'h0000_0020; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    sync_in = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    n_checks++;
    if (out_port !== 64'h000F_1234_0010_0777 || update_pulse !== 1'b1 || commit_pending !== 1'b0)
      $display("FAIL coll_active got=%h/%0b/%0b exp=000f123400100777/1/0", out_port, update_pulse, commit_pending);
    else n_pass++;
    bus_read(4'h1, rd);
    n_checks++;
    if (rd !== 32'h0000_0020) $display("FAIL coll_shadow1 got=%h exp=00000020", rd);
    else n_pass++;
    bus_read(4'h9, rd);
    n_checks++;
    if (rd !== 32'h0000_0010) $display("FAIL coll_active1 got=%h exp=00000010", rd);
    else n_pass++;
    // arm coinciding with a sync edge keeps waiting for the next edge
    @(negedge clk);
    sync_in = 1'b1;
    address = 4'hF; writedata = 32'h5; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    sync_in = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    n_checks++;
    if (commit_pending !== 1'b1 || update_pulse !== 1'b0 || out_port !== 64'h000F_1234_0010_0777)
      $display("FAIL arm_edge_same got=%0b/%0b/%h exp=1/0/000f123400100777", commit_pending, update_pulse, out_port);
    else n_pass++;
    sync_pulse();
    n_checks++;
    if (out_port !== 64'h000F_1234_0020_0777 || update_pulse !== 1'b1 || commit_pending !== 1'b0)
      $display("FAIL arm_next_edge got=%h/%0b/%0b exp=000f123400200777/1/0", out_port, update_pulse, commit_pending);
    else n_pass++;
  endtask

  task automatic test_auto_width();
    logic [31:0] rd;
    bus_write(4'hF, 32'h2);
    n_checks++;
    if (update_pulse !== 1'b0 || commit_pending !== 1'b0)
      $display("FAIL auto_enable got=%0b/%0b exp=0/0", update_pulse, commit_pending);
    else n_pass++;
    bus_write(4'h3, 32'hFFFF_ABCD);
    n_checks++;
    if (out_port !== 64'hABCD_1234_0020_0777 || update_pulse !== 1'b1)
      $display("FAIL auto_write got=%h/%0b exp=abcd123400200777/1", out_port, update_pulse);
    else n_pass++;
    bus_read(4'h3, rd);
    n_checks++;
    if (rd !== 32'h0000_ABCD) $display("FAIL auto_read_shadow3 got=%h exp=0000abcd", rd);
    else n_pass++;
    bus_read(4'h6, rd);
    n_checks++;
    if (rd !== 32'h0) $display("FAIL read_unmapped got=%h exp=00000000", rd);
    else n_pass++;
    bus_read(4'hF, rd);
    n_checks++;
    if (rd !== 32'h0000_0002) $display("FAIL auto_read_ctrl got=%h exp=00000002", rd);
    else n_pass++;
    bus_read(4'hB, rd);
    repeat (2) @(negedge clk);
    n_checks++;
    if (readdata !== 32'h0000_ABCD) $display("FAIL readdata_hold got=%h exp=0000abcd", readdata);
    else n_pass++;
    // writes to unmapped addresses are ignored
    bus_write(4'h5, 32'h0000_5555);
    n_checks++;
    if (out_port !== 64'hABCD_1234_0020_0777 || update_pulse !== 1'b0)
      $display("FAIL unmapped_write got=%h/%0b exp=abcd123400200777/0", out_port, update_pulse);
    else n_pass++;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset      = 1'b1;
    address    = 4'h0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    writedata  = 32'h0;
    sync_in    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_buffered_write();
    test_deferred_commit();
    test_cancel();
    test_collision();
    test_auto_width();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
